neurotransmitter_level_tracker: RTL and testbench

Reader-side companion to the neurotransmitter resource counters. It samples a resource's raw N-bit value every cycle and applies per-band hysteresis and a dwell filter to produce a stable 2-bit level. Each committed level change is announced to the mood/emotion logic over a valid/ready event channel. One instance sits behind each neurotransmitter resource (serotonin, dopamine, ...) and replaces the direct top-two-bit slice as the level consumed downstream.

---
 rtl/neurotransmitter_level_tracker.sv | 185 ++++++++++++++++++
 tb/tb_neurotransmitter_level_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/neurotransmitter_level_tracker.sv
// neurotransmitter_level_tracker
//
// Samples a raw resource value every cycle. It produces a stable 2-bit level
// by applying per-band hysteresis and a dwell filter. Each committed level
// change is announced on a valid/ready event channel. The filter never waits
// on the consumer: a stalled event is overwritten by the newest one.
//
// Optional feature macro: NT_TRACKER_EVT_LOST_EN
//   When defined, this adds the evt_lost_o port, a sticky overwrite flag.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous, active-high reset
//   value_i      raw resource value, N bits
//   level_o      committed, filtered level
//   evt_valid_o  level-change event pending
//   evt_level_o  level carried by the pending event
//   evt_up_o     1 = increase, 0 = decrease
//   evt_ready_i  consumer accepts the event
//   evt_lost_o   sticky overwrite flag (only with NT_TRACKER_EVT_LOST_EN)

module neurotransmitter_level_tracker #(
    parameter int unsigned N           = 7,
    parameter int unsigned HYST        = 4,
    parameter int unsigned DWELL       = 8,
    parameter int unsigned RESET_LEVEL = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] value_i,
    output logic [1:0]   level_o,
    output logic         evt_valid_o,
    output logic [1:0]   evt_level_o,
    output logic         evt_up_o,
    input  logic         evt_ready_i
`ifdef NT_TRACKER_EVT_LOST_EN
    ,
    output logic         evt_lost_o
`endif
);

    localparam int unsigned Q    = 32'd1 << (N - 2);
    localparam int unsigned VW   = N + 1;
    localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic {StStable, StPending} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic [1:0]      level_q, level_d;
    logic            evt_valid_q, evt_valid_d;
    logic [1:0]      evt_level_q, evt_level_d;
    logic            evt_up_q, evt_up_d;

    logic [N:0]      val_ext, up_thr, dn_thr;
    logic            go_up, go_down, move, commit;
    logic [1:0]      new_level;

    // Thresholds relative to the current level. They are computed one bit
    // wider than the value so that band 3 plus the margin cannot wrap.
    always_comb begin
        val_ext = {1'b0, value_i};
        up_thr  = VW'((32'(level_q) + 32'd1) * Q + HYST);
        dn_thr  = VW'(32'(level_q) * Q - HYST);
        go_up   = (level_q != 2'd3) && (val_ext >= up_thr);
        go_down = (level_q != 2'd0) && (val_ext < dn_thr);
        move    = go_up | go_down;
        new_level = go_up ? (level_q + 2'd1) : (level_q - 2'd1);
    end

    // Dwell filter: the same direction must persist for DWELL edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        level_d = level_q;
        commit  = 1'b0;
        unique case (state_q)
            StStable: begin
                if (move) begin
                    if (DWELL == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = StPending;
                        cnt_d   = CntW'(1);
                        dir_d   = go_up;
                    end
                end
            end
            StPending: begin
                if (!move) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (go_up != dir_q) begin
                    cnt_d = CntW'(1);
                    dir_d = go_up;
                end else if (cnt_q == CntW'(DWELL - 1)) begin
                    commit = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
        if (commit) begin
            state_d = StStable;
            cnt_d   = '0;
            level_d = new_level;
        end
    end

    // Event slot: a commit always wins over a simultaneous handshake.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_level_d = evt_level_q;
        evt_up_d    = evt_up_q;
        if (commit) begin
            evt_valid_d = 1'b1;
            evt_level_d = new_level;
            evt_up_d    = go_up;
        end else if (evt_valid_q && evt_ready_i) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StStable;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            level_q     <= 2'(RESET_LEVEL);
            evt_valid_q <= 1'b0;
            evt_level_q <= 2'(RESET_LEVEL);
            evt_up_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            level_q     <= level_d;
            evt_valid_q <= evt_valid_d;
            evt_level_q <= evt_level_d;
            evt_up_q    <= evt_up_d;
        end
    end

    assign level_o     = level_q;
    assign evt_valid_o = evt_valid_q;
    assign evt_level_o = evt_level_q;
    assign evt_up_o    = evt_up_q;

`ifdef NT_TRACKER_EVT_LOST_EN
    logic evt_lost_q, evt_lost_d;
    // Set when the slot currently holds an event that replaced an unread one.
    logic ovw_q, ovw_d;

    always_comb begin
        evt_lost_d = evt_lost_q;
        ovw_d      = ovw_q;
        if (commit) begin
            if (evt_valid_q && !evt_ready_i) begin
                evt_lost_d = 1'b1;
                ovw_d      = 1'b1;
            end else begin
                ovw_d = 1'b0;
            end
        end else if (evt_valid_q && evt_ready_i && !ovw_q) begin
            evt_lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_lost_q <= 1'b0;
            ovw_q      <= 1'b0;
        end else begin
            evt_lost_q <= evt_lost_d;
            ovw_q      <= ovw_d;
        end
    end

    assign evt_lost_o = evt_lost_q;
`endif

endmodule

// File: tb/tb_neurotransmitter_level_tracker.sv
// Bench for neurotransmitter_level_tracker (N=7, HYST=4, DWELL=8, Q=32).
// A behavioural model predicts the level and the event slot. Every event it
// expects to be accepted is queued. A monitor pops one entry per DUT
// handshake and compares it with the event.

module tb_neurotransmitter_level_tracker;

    localparam int Q     = 32;
    localparam int HYST  = 4;
    localparam int DWELL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] value = 7'd96;
    logic [1:0] level;
    logic       evt_valid;
    logic [1:0] evt_level;
    logic       evt_up;
    logic       evt_ready = 1'b0;
`ifdef NT_TRACKER_EVT_LOST_EN
    logic       evt_lost;
`endif

    neurotransmitter_level_tracker #(
        .N(7), .HYST(4), .DWELL(8), .RESET_LEVEL(3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .value_i     (value),
        .level_o     (level),
        .evt_valid_o (evt_valid),
        .evt_level_o (evt_level),
        .evt_up_o    (evt_up),
        .evt_ready_i (evt_ready)
`ifdef NT_TRACKER_EVT_LOST_EN
        ,
        .evt_lost_o  (evt_lost)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Model state
    int m_lvl, m_run, m_dir;
    bit m_valid, m_up, m_lost, m_ovw;
    int m_elvl;
    logic [2:0] exp_q[$];   // {level, up} of events expected to be accepted
    logic [2:0] e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl = 3; m_run = 0; m_dir = 0;
        m_valid = 0; m_elvl = 3; m_up = 0; m_lost = 0; m_ovw = 0;
        exp_q.delete();
    endtask

    // Effect of one sampling edge with inputs v and r.
    task automatic model_edge(input int v, input bit r);
        int  dir;
        bit  hs;
        bit  commit;
        dir = 0;
        if (m_lvl < 3 && v >= (m_lvl + 1) * Q + HYST) dir = 1;
        else if (m_lvl > 0 && v < m_lvl * Q - HYST) dir = -1;
        if (dir == 0) m_run = 0;
        else if (dir == m_dir) m_run++;
        else m_run = 1;
        m_dir  = dir;
        commit = (m_run == DWELL);
        hs     = m_valid && r;
        if (hs) exp_q.push_back({2'(m_elvl), m_up});
        if (commit) begin
            m_lvl = m_lvl + dir;
            m_run = 0;
            m_dir = 0;
            if (m_valid && !r) begin
                m_lost = 1; m_ovw = 1;
            end else begin
                m_ovw = 0;
            end
            m_valid = 1; m_elvl = m_lvl; m_up = (dir > 0);
        end else if (hs) begin
            m_valid = 0;
            if (!m_ovw) m_lost = 0;
        end
    endtask

    task automatic auto_check();
        chk("level", 32'(level), 32'(m_lvl));
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        if (m_valid) begin
            chk("evt_level", 32'(evt_level), 32'(m_elvl));
            chk("evt_up", 32'(evt_up), 32'(m_up));
        end
`ifdef NT_TRACKER_EVT_LOST_EN
        chk("evt_lost", 32'(evt_lost), 32'(m_lost));
`endif
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input int v, input bit r);
        value     = 7'(v);
        evt_ready = r;
        model_edge(v, r);
        @(posedge clk);
        #1;
        auto_check();
    endtask

    // Monitor: a handshake happens on the next edge whenever valid && ready here.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL evt_handshake: got event level %0d up %0d, required none",
                         evt_level, evt_up);
            end else begin
                e = exp_q.pop_front();
                chk("hs_level", 32'(evt_level), 32'(e[2:1]));
                chk("hs_up", 32'(evt_up), 32'(e[0]));
            end
        end
    end

    initial begin
        int v, hold;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", 32'(level), 32'd3);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt_level", 32'(evt_level), 32'd3);
        chk("rst_evt_up", 32'(evt_up), 32'd0);
        rst = 1'b0;

        // Decrease 3 -> 2 after exactly 8 edges below 92
        repeat (7) step(90, 0);
        chk("dwell7_level", 32'(level), 32'd3);
        step(90, 0);
        chk("dwell8_level", 32'(level), 32'd2);
        chk("dwell8_valid", 32'(evt_valid), 32'd1);
        chk("dwell8_evt_level", 32'(evt_level), 32'd2);
        chk("dwell8_evt_up", 32'(evt_up), 32'd0);
        step(90, 1);
        chk("accept_valid", 32'(evt_valid), 32'd0);

        // Asynchronous reset in the middle of PENDING
        repeat (4) step(0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_level", 32'(level), 32'd3);
        chk("midrst_valid", 32'(evt_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (7) step(90, 1);
        chk("cnt_cleared_level", 32'(level), 32'd3);
        step(90, 1);
        chk("after_rst_level", 32'(level), 32'd2);

        // Inside the hysteresis margin: no change
        repeat (50) step(97, 1);
        chk("hyst_level", 32'(level), 32'd2);
        chk("hyst_valid", 32'(evt_valid), 32'd0);
        repeat (8) step(100, 1);
        chk("up_level", 32'(level), 32'd3);
        chk("up_evt_up", 32'(evt_up), 32'd1);

        // Back to 2, then an interrupted dwell
        repeat (8) step(90, 1);
        repeat (7) step(110, 1);
        step(80, 1);
        repeat (10) step(80, 1);
        chk("abort_level", 32'(level), 32'd2);
        chk("abort_valid", 32'(evt_valid), 32'd0);
        repeat (8) step(110, 1);
        step(96, 1);

        // Stalled consumer: two commits, the first one overwritten
        repeat (16) step(0, 0);
        chk("stall_level", 32'(level), 32'd1);
        chk("stall_evt_level", 32'(evt_level), 32'd1);
`ifdef NT_TRACKER_EVT_LOST_EN
        chk("stall_lost", 32'(evt_lost), 32'd1);
`endif
        step(40, 1);
        chk("stall_drain_valid", 32'(evt_valid), 32'd0);

        // Commit coincident with a handshake
        repeat (8) step(0, 0);
        repeat (7) step(127, 0);
        step(127, 1);
        chk("coinc_valid", 32'(evt_valid), 32'd1);
        chk("coinc_level", 32'(evt_level), 32'd1);
        chk("coinc_up", 32'(evt_up), 32'd1);
`ifdef NT_TRACKER_EVT_LOST_EN
        chk("coinc_lost", 32'(evt_lost), 32'd1);
`endif
        step(40, 1);
`ifdef NT_TRACKER_EVT_LOST_EN
        chk("clean_accept_lost", 32'(evt_lost), 32'd0);
`endif

        // Random phase
        hold = 0;
        v    = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                v    = int'($urandom_range(0, 127));
                hold = int'($urandom_range(1, 24));
            end
            hold--;
            step(v, $urandom_range(0, 3) != 0);
        end
        repeat (2) step(v, 1);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
